// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline; define HAZ_PERF_CNT_EN to add stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] Rs1E,
  input  logic [ADDR_W-1:0] Rs2E,
  input  logic [ADDR_W-1:0] RdE,
  input  logic [ADDR_W-1:0] RdM,
  input  logic [ADDR_W-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MulDivE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdDone
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic md_stall, lw_stall, m_hit_a, m_hit_b, w_hit_a, w_hit_b;
  assign m_hit_a = RegWriteM && RdM != '0 && RdM == Rs1E;
  assign m_hit_b = RegWriteM && RdM != '0 && RdM == Rs2E;
  assign w_hit_a = RegWriteW && RdW != '0 && RdW == Rs1E;
  assign w_hit_b = RegWriteW && RdW != '0 && RdW == Rs2E;
  assign ForwardAE = m_hit_a ? 2'b10 : w_hit_a ? 2'b01 : 2'b00;
  assign ForwardBE = m_hit_b ? 2'b10 : w_hit_b ? 2'b01 : 2'b00;
  assign lw_stall = ResultSrcE0 && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    md_stall = 1'b0;
    MdDone   = 1'b0;
    case (state)
      IDLE: if (MulDivE) begin
        md_stall = 1'b1;
        cnt_n    = 4'(MULDIV_LAT - 1);
        state_n  = BUSY;
      end
      BUSY: begin
        md_stall = 1'b1;
        cnt_n    = cnt - 4'd1;
        state_n  = cnt == 4'd1 ? RELEASE : BUSY;
      end
      RELEASE: begin
        MdDone  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // reset overrides everything: no stalls, bubbles into every stage
  assign StallE = !rst && md_stall;
  assign StallF = !rst && (md_stall || (!PCSrcE && lw_stall));
  assign StallD = StallF;
  assign FlushM = rst || md_stall;
  assign FlushD = rst || (!md_stall && PCSrcE);
  assign FlushE = rst || (!md_stall && (PCSrcE || lw_stall));
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if ((StallF || StallD || StallE) && !(&StallCnt)) StallCnt <= StallCnt + 32'd1;
      if ((FlushD || FlushE || FlushM) && !(&FlushCnt)) FlushCnt <= FlushCnt + 32'd1;
    end
`endif
endmodule
